// File: rtl/clct_busy_marker_cclut.sv
// Busy-window marker for the ccLUT best-1-of-5 sorter.
// Each accepted trigger marks every key group overlapping key +/- SPREAD
// half-strips busy for DEAD_TIME clocks. The last accepted pattern, key and
// carry are held for readout.
module clct_busy_marker_cclut #(
  parameter int NGRP      = 5,
  parameter int MXKEYB    = 5,
  parameter int MXKEYBX   = 8,
  parameter int MXPATB    = 6,
  parameter int MXPATC    = 12,
  parameter int SPREAD    = 2,
  parameter int DEAD_TIME = 4,
  parameter int MXDEADB   = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                trig_vld,
  input  logic [MXPATB-1:0]   best_pat,
  input  logic [MXKEYBX-1:0]  best_key,
  input  logic [MXPATC-1:0]   best_carry,
  input  logic                best_bsy,
  input  logic                dead_clr,
  output logic [NGRP-1:0]     bsy,
  output logic                bsy_any,
  output logic                last_vld,
  output logic [MXPATB-1:0]   last_pat,
  output logic [MXKEYBX-1:0]  last_key,
  output logic [MXPATC-1:0]   last_carry,
  output logic                key_err
);

  // Two extra bits keep key +/- SPREAD representable as a signed value.
  localparam int WW = MXKEYBX + 2;
  localparam int GW = MXKEYBX - MXKEYB;
  localparam logic signed [WW-1:0] SPREAD_S = WW'(SPREAD);
  localparam logic signed [WW-1:0] KEYMAX_S = WW'(NGRP * (2**MXKEYB) - 1);
  localparam logic [MXDEADB-1:0]   DT_LOAD  = MXDEADB'(DEAD_TIME);
  localparam bit                   DT_EN    = (DEAD_TIME != 0);

  logic [GW-1:0]             grp;
  logic                      grp_ok;
  logic                      trig_ok;
  logic                      acc;
  logic signed [WW-1:0]      key_s;
  logic signed [WW-1:0]      lo_raw;
  logic signed [WW-1:0]      hi_raw;
  logic signed [WW-1:0]      lo;
  logic signed [WW-1:0]      hi;
  logic [NGRP-1:0]           hit;
  logic [NGRP-1:0][MXDEADB-1:0] cnt;

  assign grp     = best_key[MXKEYBX-1:MXKEYB];
  assign grp_ok  = (32'(grp) < NGRP);
  assign trig_ok = trig_vld & ~best_bsy;
  assign acc     = trig_ok & grp_ok;

  // Busy window around the key, clamped to the valid half-strip range.
  always_comb begin
    key_s  = signed'({2'b00, best_key});
    lo_raw = key_s - SPREAD_S;
    hi_raw = key_s + SPREAD_S;
    lo     = lo_raw[WW-1] ? '0 : lo_raw;
    hi     = (hi_raw > KEYMAX_S) ? KEYMAX_S : hi_raw;
  end

  for (genvar g = 0; g < NGRP; g++) begin : g_hit
    localparam logic signed [WW-1:0] BASE = WW'(g * (2**MXKEYB));
    localparam logic signed [WW-1:0] TOP  = WW'(g * (2**MXKEYB) + (2**MXKEYB) - 1);
    assign hit[g] = (BASE <= hi) && (TOP >= lo);
  end

  // Per-group dead-time counters: reload on hit, else clear, else count down.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else begin
      for (int unsigned g = 0; g < NGRP; g++) begin
        if (acc && hit[g] && DT_EN) begin
          cnt[g] <= DT_LOAD;
        end else if (dead_clr) begin
          cnt[g] <= '0;
        end else if (cnt[g] != '0) begin
          cnt[g] <= cnt[g] - 1'b1;
        end
      end
    end
  end

  // Busy flags decoded from the registered counters.
  always_comb begin
    bsy = '0;
    for (int unsigned g = 0; g < NGRP; g++) begin
      bsy[g] = (cnt[g] != '0);
    end
    bsy_any = |bsy;
  end

  // Capture of the last accepted trigger and out-of-range key flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_vld   <= 1'b0;
      last_pat   <= '0;
      last_key   <= '0;
      last_carry <= '0;
      key_err    <= 1'b0;
    end else begin
      key_err <= trig_ok & ~grp_ok;
      if (acc) begin
        last_vld   <= 1'b1;
        last_pat   <= best_pat;
        last_key   <= best_key;
        last_carry <= best_carry;
      end
    end
  end

endmodule
